// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - memory-mapped interrupt controller with fixed/round-robin arbitration
module intr_controller #(
  parameter int              BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hF0000A00,
  parameter int              NSRC = 4
) (
  input  logic            CLK,
  input  logic            LOCK,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic            FLUSH,
  input  logic [NSRC-1:0] IRQ_IN,
  input  logic            IACK,
  output logic            INTR,
  output logic [2:0]      IVEC
);

  localparam logic [BITS-1:0] A_CTRL   = BASE;
  localparam logic [BITS-1:0] A_MASK   = BASE + BITS'(32'h4);
  localparam logic [BITS-1:0] A_STATUS = BASE + BITS'(32'h8);
  localparam logic [BITS-1:0] A_EOI    = BASE + BITS'(32'hC);
  localparam logic [BITS-1:0] A_CNT    = BASE + BITS'(32'h10);
  localparam logic [3:0]      NSRC4    = 4'(NSRC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ctrl_q, ctrl_d;       // bit0 GIE, bit1 RR
  logic [NSRC-1:0] mask_q, mask_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      ptr_q, ptr_d;         // round-robin search start
  logic [2:0]      ivec_q, ivec_d;
  logic            intr_q, intr_d;
  logic            hold_q, hold_d;       // blocks arbitration on the edge right after EOI

  logic sel_ctrl, sel_mask, sel_status, sel_eoi, sel_cnt, sel_any;
  logic wr_ctrl, wr_mask, wr_eoi, wr_cnt;
  logic [7:0]      elig8;
  logic [2:0]      win;
  logic            found;
  logic [3:0]      ivec_inc;
  logic [2:0]      ptr_wrap;
  logic            cnt_inc;
  logic [BITS-1:0] rdata;
  logic            unused_dbus;

  // Exact-address decode; a pipeline flush deselects everything
  always_comb begin
    sel_ctrl   = !FLUSH && (ABUS == A_CTRL);
    sel_mask   = !FLUSH && (ABUS == A_MASK);
    sel_status = !FLUSH && (ABUS == A_STATUS);
    sel_eoi    = !FLUSH && (ABUS == A_EOI);
    sel_cnt    = !FLUSH && (ABUS == A_CNT);
    sel_any    = sel_ctrl || sel_mask || sel_status || sel_eoi || sel_cnt;
    wr_ctrl    = sel_ctrl && WE;
    wr_mask    = sel_mask && WE;
    wr_eoi     = sel_eoi  && WE;
    wr_cnt     = sel_cnt  && WE;
  end

  // Eligible sources, padded to 8 bits so a 3-bit vector can index it directly
  always_comb begin
    elig8 = '0;
    elig8[NSRC-1:0] = IRQ_IN & mask_q & {NSRC{ctrl_q[0]}};
  end

  // Pick the first eligible source, starting at 0 or at PTR when round-robin is on
  always_comb begin
    int idx;
    idx   = 0;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      idx = i + (ctrl_q[1] ? int'(ptr_q) : 0);
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && elig8[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  // Next round-robin start is the source after the one just acknowledged
  always_comb begin
    ivec_inc = {1'b0, ivec_q} + 4'd1;
    ptr_wrap = (ivec_inc >= NSRC4) ? 3'd0 : ivec_inc[2:0];
  end

  // Next-state logic: register writes, arbitration FSM and delivered count
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ivec_d  = ivec_q;
    hold_d  = 1'b0;
    cnt_inc = 1'b0;

    if (wr_ctrl) ctrl_d = DBUS[1:0];
    if (wr_mask) mask_d = DBUS[NSRC-1:0];

    case (state_q)
      S_IDLE: begin
        if (!hold_q && found) begin
          state_d = S_REQ;
          ivec_d  = win;
        end
      end
      S_REQ: begin
        // Acknowledge beats a simultaneous withdrawal
        if (IACK) begin
          state_d = S_SVC;
          cnt_inc = 1'b1;
          ptr_d   = ptr_wrap;
        end else if (!elig8[ivec_q]) begin
          state_d = S_IDLE;
        end
      end
      S_SVC: begin
        // Only EOI ends service; GIE/MASK changes here are deliberately ignored
        if (wr_eoi) begin
          state_d = S_IDLE;
          hold_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear write wins over a same-edge increment
    if (wr_cnt)       cnt_d = 16'd0;
    else if (cnt_inc) cnt_d = cnt_q + 16'd1;

    intr_d = (state_d == S_REQ);
  end

  // State and register update; PLL lock loss resets everything at once
  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      state_q <= S_IDLE;
      ctrl_q  <= 2'd0;
      mask_q  <= '0;
      cnt_q   <= 16'd0;
      ptr_q   <= 3'd0;
      ivec_q  <= 3'd0;
      intr_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ivec_q  <= ivec_d;
      intr_q  <= intr_d;
      hold_q  <= hold_d;
    end
  end

  // Combinational read data from current register values
  always_comb begin
    rdata = '0;
    if (sel_ctrl) begin
      rdata[1:0] = ctrl_q;
    end else if (sel_mask) begin
      rdata[NSRC-1:0] = mask_q;
    end else if (sel_status) begin
      rdata[NSRC-1:0] = IRQ_IN;
      rdata[17:16]    = state_q;
      rdata[26:24]    = ivec_q;
    end else if (sel_cnt) begin
      rdata[15:0] = cnt_q;
    end
  end

  // Drive the bus only for a selected read outside reset
  assign DBUS = (LOCK && sel_any && !WE) ? rdata : {BITS{1'bz}};

  assign unused_dbus = ^DBUS;
  assign INTR = intr_q;
  assign IVEC = ivec_q;

endmodule
